stopwatch_ctrl: RTL

STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

---
 rtl/stopwatch_ctrl.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: button sync/debounce, tick prescaler and run/pause/clear FSM.
// Define STOPWATCH_LAP_EN to build the lap (display freeze) logic; otherwise Freeze is tied low.
module stopwatch_ctrl #(
    parameter int CLK_HZ          = 50000000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       BtnStartStop,
    input  logic       BtnClear,
    input  logic       BtnLap,
    output logic       Tick,
    output logic       ClearCount,
    output logic       Running,
    output logic [1:0] State,
    output logic       Freeze
);

    localparam int DIV     = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = (DIV > 2) ? $clog2(DIV) : 1;
    localparam int DEB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(DIV - 1);
    localparam logic [DEB_W-1:0]   DEB_LAST   = DEB_W'(DEBOUNCE_CYCLES - 1);
    localparam int NBTN = 3;

    if (DIV < 2) begin : g_div_check
        $error("stopwatch_ctrl: CLK_HZ/TICK_HZ must be at least 2");
    end

    // state    | meaning
    // IDLE     | count cleared, prescaler held at zero
    // RUNNING  | prescaler advancing, Tick issued on each wrap
    // PAUSED   | prescaler and digits hold their value
    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_RUNNING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    logic [NBTN-1:0]  btn_raw;
    logic [NBTN-1:0]  sync1_q, sync1_d;
    logic [NBTN-1:0]  sync2_q, sync2_d;
    logic [NBTN-1:0]  level_q, level_d;
    logic [NBTN-1:0]  press_q, press_d;
    logic [DEB_W-1:0] cnt_q [NBTN];
    logic [DEB_W-1:0] cnt_d [NBTN];

    state_t               state_q, state_d;
    logic [PRESC_W-1:0]   presc_q, presc_d;
    logic                 tick_q, tick_d;
    logic                 clear_q, clear_d;
    logic                 start_evt, clear_evt, lap_evt;

    assign btn_raw   = {BtnLap, BtnClear, BtnStartStop};
    assign start_evt = press_q[0];
    assign clear_evt = press_q[1];
    assign lap_evt   = press_q[2];

    // The deviation counter restarts whenever the synchronized level agrees with the accepted one.
    always_comb begin
        sync1_d = btn_raw;
        sync2_d = sync1_q;
        level_d = level_q;
        press_d = '0;
        for (int i = 0; i < NBTN; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != level_q[i]) begin
                if (cnt_q[i] == DEB_LAST) begin
                    level_d[i] = sync2_q[i];
                    press_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            level_q <= '0;
            press_q <= '0;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            level_q <= level_d;
            press_q <= press_d;
            for (int i = 0; i < NBTN; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    // Tick depends only on the current state, so a wrap on the pausing edge still ticks.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick_d  = 1'b0;
        clear_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                presc_d = '0;
                if (clear_evt) begin
                    clear_d = 1'b1;
                end else if (start_evt) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (presc_q == PRESC_LAST) begin
                    presc_d = '0;
                    tick_d  = 1'b1;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
                if (start_evt) begin
                    state_d = ST_PAUSED;
                end
            end
            ST_PAUSED: begin
                if (clear_evt) begin
                    state_d = ST_IDLE;
                    clear_d = 1'b1;
                    presc_d = '0;
                end else if (start_evt) begin
                    state_d = ST_RUNNING;
                end
            end
            default: begin
                state_d = ST_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            tick_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            tick_q  <= tick_d;
            clear_q <= clear_d;
        end
    end

    assign Tick       = tick_q;
    assign ClearCount = clear_q;
    assign Running    = (state_q == ST_RUNNING);
    assign State      = state_q;

`ifdef STOPWATCH_LAP_EN
    logic freeze_q, freeze_d;

    always_comb begin
        freeze_d = freeze_q;
        if (state_d == ST_IDLE) begin
            freeze_d = 1'b0;
        end else if (lap_evt) begin
            if (state_q == ST_RUNNING) begin
                freeze_d = ~freeze_q;
            end else if (state_q == ST_PAUSED) begin
                freeze_d = 1'b0;
            end
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            freeze_q <= 1'b0;
        end else begin
            freeze_q <= freeze_d;
        end
    end

    assign Freeze = freeze_q;
`else
    logic unused_lap_evt;
    assign unused_lap_evt = lap_evt;
    assign Freeze         = 1'b0;
`endif

endmodule
